// File: rtl/rand_req_arbiter_if.sv
// Request/grant/data bundle between the shared random source and its requesters.
// The slave side is the arbiter; the master side drives requests and reseeds.
interface rand_req_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int OUT_W = 30
);
  logic             seed_load;
  logic [29:0]      seed_in;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             rnd_valid;
  logic [OUT_W-1:0] rnd_data;
  logic             busy;

  modport master (
    output seed_load, seed_in, req,
    input  gnt, rnd_valid, rnd_data, busy
  );

  modport slave (
    input  seed_load, seed_in, req,
    output gnt, rnd_valid, rnd_data, busy
  );
endinterface

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter in front of one 30-bit Fibonacci LFSR (taps 30,6,4,1).
// Each winner gets one word after STIR_CYCLES shifts, with a one-cycle gnt/rnd_valid pulse.
module rand_req_arbiter #(
  parameter int          NREQ        = 4,
  parameter int          OUT_W       = 30,
  parameter int          STIR_CYCLES = 30,
  parameter logic [29:0] SEED        = 30'h0000000A
) (
  input logic               clk,
  input logic               rst_n,
  rand_req_arbiter_if.slave bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (STIR_CYCLES > 1) ? $clog2(STIR_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STIR_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    STIR = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [29:0]      lfsr_reg, lfsr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0] win_idx_reg, win_idx_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic             rnd_valid_reg, rnd_valid_next;
  logic [OUT_W-1:0] rnd_data_reg, rnd_data_next;

  logic [29:0]      lfsr_step;
  logic [29:0]      seed_safe;
  logic [NREQ-1:0]  req_upper;
  logic [IDX_W-1:0] upper_idx;
  logic [IDX_W-1:0] lower_idx;
  logic [IDX_W-1:0] win_sel;

  assign lfsr_step = {lfsr_reg[28:0], lfsr_reg[29] ^ lfsr_reg[5] ^ lfsr_reg[3] ^ lfsr_reg[0]};
  // A zero seed would lock the LFSR; fall back to the built-in seed instead.
  assign seed_safe = (bus.seed_in == 30'd0) ? SEED : bus.seed_in;

  // Requesters at or after the pointer win first; otherwise the search wraps to index 0.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
      assign req_upper[gi] = bus.req[gi] && (IDX_W'(gi) >= rr_ptr_reg);
    end
  endgenerate

  always_comb begin
    upper_idx = '0;
    lower_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_upper[i]) begin
        upper_idx = IDX_W'(i);
      end
      if (bus.req[i]) begin
        lower_idx = IDX_W'(i);
      end
    end
    win_sel = (|req_upper) ? upper_idx : lower_idx;
  end

  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    cnt_next       = cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    win_idx_next   = win_idx_reg;
    gnt_next       = '0;
    rnd_valid_next = 1'b0;
    rnd_data_next  = rnd_data_reg;

    if (bus.seed_load) begin
      lfsr_next  = seed_safe;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            win_idx_next = win_sel;
            cnt_next     = '0;
            state_next   = STIR;
          end
        end
        STIR: begin
          lfsr_next = lfsr_step;
          cnt_next  = cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            rnd_data_next  = lfsr_step[OUT_W-1:0];
            rnd_valid_next = 1'b1;
            gnt_next       = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_reg;
            rr_ptr_next    = (win_idx_reg == IDX_LAST) ? '0 : win_idx_reg + 1'b1;
            cnt_next       = '0;
            state_next     = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lfsr_reg      <= SEED;
      cnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      win_idx_reg   <= '0;
      gnt_reg       <= '0;
      rnd_valid_reg <= 1'b0;
      rnd_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      cnt_reg       <= cnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      win_idx_reg   <= win_idx_next;
      gnt_reg       <= gnt_next;
      rnd_valid_reg <= rnd_valid_next;
      rnd_data_reg  <= rnd_data_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.rnd_valid = rnd_valid_reg;
  assign bus.rnd_data  = rnd_data_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Directed bench for rand_req_arbiter: a fast instance (one stir per word) and a
// slow instance (thirty stirs per word) checked against hand values and an LFSR model.
module tb_rand_req_arbiter;

  localparam logic [29:0] SEED = 30'h0000000A;
  localparam int NGRANTS = 1000;

  logic clk = 1'b0;
  logic rst_n1 = 1'b0;
  logic rst_n30 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rand_req_arbiter_if #(.NREQ(4), .OUT_W(30)) bus1 ();
  rand_req_arbiter_if #(.NREQ(4), .OUT_W(30)) bus30 ();

  rand_req_arbiter #(.NREQ(4), .OUT_W(30), .STIR_CYCLES(1), .SEED(SEED)) dut1 (
    .clk(clk), .rst_n(rst_n1), .bus(bus1)
  );

  rand_req_arbiter #(.NREQ(4), .OUT_W(30), .STIR_CYCLES(30), .SEED(SEED)) dut30 (
    .clk(clk), .rst_n(rst_n30), .bus(bus30)
  );

  function automatic logic [29:0] model_step(input logic [29:0] x);
    // Taps 30,6,4,1 are bits 29,5,3,0.
    return {x[28:0], ^(x & 30'h2000_0029)};
  endfunction

  function automatic logic [29:0] model_n(input logic [29:0] x, input int n);
    logic [29:0] v;
    v = x;
    for (int k = 0; k < n; k++) v = model_step(v);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset1();
    rst_n1 = 1'b0;
    tick();
    rst_n1 = 1'b1;
    tick();
  endtask

  task automatic do_reset30();
    rst_n30 = 1'b0;
    tick();
    rst_n30 = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus1.req = 4'b0000; bus1.seed_load = 1'b0; bus1.seed_in = 30'd0;
    bus30.req = 4'b0000; bus30.seed_load = 1'b0; bus30.seed_in = 30'd0;
    rst_n1 = 1'b0; rst_n30 = 1'b0;
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus1.gnt); end
    checks++; if (bus1.rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus1.rnd_valid); end
    checks++; if (bus1.rnd_data !== 30'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus1.rnd_data); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus1.busy); end
    checks++; if (bus30.busy !== 1'b0) begin errors++; $display("FAIL reset_busy30: got %b expected 0", bus30.busy); end
    rst_n1 = 1'b1; rst_n30 = 1'b1;
    tick();
    $display("reset: outputs idle");
  endtask

  task automatic test_single();
    bus1.req = 4'b0001;
    tick();
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus1.busy); end
    checks++; if (bus1.rnd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", bus1.rnd_valid); end
    tick();
    checks++; if (bus1.rnd_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus1.rnd_valid); end
    checks++; if (bus1.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", bus1.gnt); end
    checks++; if (bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL single_data: got %h expected 15", bus1.rnd_data); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus1.busy); end
    $display("single: gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
    bus1.req = 4'b0000;
    tick();
    checks++; if (bus1.rnd_valid !== 1'b0 || bus1.gnt !== 4'b0000) begin errors++; $display("FAIL single_pulse: got valid=%b gnt=%b expected 0/0000", bus1.rnd_valid, bus1.gnt); end
    checks++; if (bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL single_hold: got %h expected 15", bus1.rnd_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eg [5];
    logic [29:0] ed [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{30'h15, 30'h2B, 30'h57, 30'hAF, 30'h15F};
    do_reset1();
    bus1.req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus1.rnd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus1.rnd_valid); end
      checks++; if (bus1.gnt !== eg[i]) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, bus1.gnt, eg[i]); end
      checks++; if (bus1.rnd_data !== ed[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus1.rnd_data, ed[i]); end
      $display("b2b: gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
      if (i == 4) bus1.req = 4'b0000;
      tick();
      checks++; if (bus1.rnd_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap[%0d]: got %b expected 0", i, bus1.rnd_valid); end
      checks++; if (bus1.busy !== (i < 4)) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, bus1.busy, (i < 4)); end
    end
  endtask

  task automatic test_seed_fast();
    do_reset1();
    bus1.req = 4'b1111;
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0001) begin errors++; $display("FAIL seedf_first_gnt: got %b expected 0001", bus1.gnt); end
    tick();
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL seedf_busy: got %b expected 1", bus1.busy); end
    bus1.seed_load = 1'b1; bus1.seed_in = 30'd0;
    tick();
    bus1.seed_load = 1'b0;
    checks++; if (bus1.rnd_valid !== 1'b0 || bus1.gnt !== 4'b0000) begin errors++; $display("FAIL seedf_abort: got valid=%b gnt=%b expected 0/0000", bus1.rnd_valid, bus1.gnt); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL seedf_idle: got %b expected 0", bus1.busy); end
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0010) begin errors++; $display("FAIL seedf_gnt: got %b expected 0010", bus1.gnt); end
    checks++; if (bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL seedf_data: got %h expected 15", bus1.rnd_data); end
    $display("seed fast: gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
    bus1.req = 4'b0000;
    tick();
  endtask

  task automatic test_seed_slow();
    int n;
    logic [29:0] exp_d;
    do_reset30();
    bus30.req = 4'b0011;
    for (int i = 0; i < 11; i++) tick();
    bus30.seed_load = 1'b1; bus30.seed_in = 30'd0;
    tick();
    bus30.seed_load = 1'b0;
    checks++; if (bus30.rnd_valid !== 1'b0 || bus30.gnt !== 4'b0000) begin errors++; $display("FAIL seeds_abort: got valid=%b gnt=%b expected 0/0000", bus30.rnd_valid, bus30.gnt); end
    checks++; if (bus30.busy !== 1'b0) begin errors++; $display("FAIL seeds_idle: got %b expected 0", bus30.busy); end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus30.rnd_valid === 1'b1) break;
    end
    exp_d = model_n(SEED, 30);
    checks++; if (n !== 31) begin errors++; $display("FAIL seeds_latency: got %0d expected 31", n); end
    checks++; if (bus30.gnt !== 4'b0001) begin errors++; $display("FAIL seeds_gnt: got %b expected 0001", bus30.gnt); end
    checks++; if (bus30.rnd_data !== exp_d) begin errors++; $display("FAIL seeds_data: got %h expected %h", bus30.rnd_data, exp_d); end
    $display("seed slow: gnt=%b data=%h after %0d cycles", bus30.gnt, bus30.rnd_data, n);
    bus30.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_stir();
    do_reset1();
    bus1.req = 4'b1111;
    tick(); tick();
    checks++; if (bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL rst_pre_data: got %h expected 15", bus1.rnd_data); end
    tick();
    checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", bus1.busy); end
    #1 rst_n1 = 1'b0;
    #1;
    checks++; if (bus1.gnt !== 4'b0000 || bus1.rnd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_pulse: got gnt=%b valid=%b expected 0000/0", bus1.gnt, bus1.rnd_valid); end
    checks++; if (bus1.rnd_data !== 30'd0) begin errors++; $display("FAIL rst_async_data: got %h expected 0", bus1.rnd_data); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", bus1.busy); end
    tick();
    checks++; if (bus1.rnd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_gnt: got %b expected 0", bus1.rnd_valid); end
    rst_n1 = 1'b1;
    bus1.req = 4'b0001;
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0001 || bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL rst_after: got gnt=%b data=%h expected 0001/15", bus1.gnt, bus1.rnd_data); end
    $display("reset mid-stir: next gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
    bus1.req = 4'b0000;
    tick();
  endtask

  task automatic test_rr_skip();
    do_reset1();
    bus1.req = 4'b0100;
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0100) begin errors++; $display("FAIL rr_gnt_a: got %b expected 0100", bus1.gnt); end
    checks++; if (bus1.rnd_data !== 30'h15) begin errors++; $display("FAIL rr_data_a: got %h expected 15", bus1.rnd_data); end
    $display("rr: gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
    bus1.req = 4'b0011;
    tick(); tick();
    checks++; if (bus1.gnt !== 4'b0001) begin errors++; $display("FAIL rr_gnt_b: got %b expected 0001", bus1.gnt); end
    checks++; if (bus1.rnd_data !== 30'h2B) begin errors++; $display("FAIL rr_data_b: got %h expected 2B", bus1.rnd_data); end
    $display("rr: gnt=%b data=%h", bus1.gnt, bus1.rnd_data);
    bus1.req = 4'b0000;
    tick();
  endtask

  task automatic test_long_run();
    logic [29:0] model;
    logic [3:0]  egnt;
    int exp_idx;
    int n;
    do_reset30();
    bus30.seed_load = 1'b1; bus30.seed_in = 30'h2345678;
    tick();
    bus30.seed_load = 1'b0;
    checks++; if (bus30.busy !== 1'b0 || bus30.rnd_data !== 30'd0) begin errors++; $display("FAIL long_seed_idle: got busy=%b data=%h expected 0/0", bus30.busy, bus30.rnd_data); end
    model = 30'h2345678;
    exp_idx = 0;
    bus30.req = 4'b1111;
    for (int g = 0; g < NGRANTS; g++) begin
      n = 0;
      while (n < 40) begin
        tick();
        n++;
        if (bus30.rnd_valid === 1'b1) break;
      end
      checks++;
      if (bus30.rnd_valid !== 1'b1 || n !== 31) begin
        errors++;
        $display("FAIL long_timing[%0d]: got valid=%b after %0d cycles expected 1 after 31", g, bus30.rnd_valid, n);
        break;
      end
      model = model_n(model, 30);
      egnt = 4'(1 << exp_idx);
      checks++; if (bus30.rnd_data !== model) begin errors++; $display("FAIL long_data[%0d]: got %h expected %h", g, bus30.rnd_data, model); end
      checks++; if (bus30.rnd_data === 30'd0) begin errors++; $display("FAIL long_nonzero[%0d]: got %h expected nonzero", g, bus30.rnd_data); end
      checks++; if (bus30.gnt !== egnt) begin errors++; $display("FAIL long_gnt[%0d]: got %b expected %b", g, bus30.gnt, egnt); end
      $display("long: grant %0d gnt=%b data=%h", g, bus30.gnt, bus30.rnd_data);
      exp_idx = (exp_idx + 1) % 4;
    end
    bus30.req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_seed_fast();
    test_seed_slow();
    test_reset_mid_stir();
    test_rr_skip();
    test_long_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
